// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default
// frame/oversampling constants. Also consumed by uart_tx.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;   // data bits per frame, LSB first
  localparam int OVERSAMPLE_DEF = 16;  // ticks per bit period (even, >= 4)
  localparam int DIV_WIDTH_DEF  = 16;  // baud divisor width

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator. Counts 0..baud_div and raises tick on the
// cycle the count equals baud_div, then wraps. clear holds the count at 0
// so the tick phase can be aligned to an external event (start-bit edge).
// Ports:
//   uart_clk  clock
//   rst_n     synchronous active-low reset
//   clear     hold counter at 0, suppress tick
//   baud_div  tick period minus one
//   tick      one-cycle oversample strobe
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 uart_clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign tick = !clear && (r_cnt == baud_div);

  always_ff @(posedge uart_clk) begin
    if (!rst_n)              r_cnt <= '0;
    else if (clear || tick)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, oversamples it, deframes 8N1-style
// characters and presents each byte on a valid/ready interface.
// Ports:
//   uart_clk, rst_n     clock, synchronous active-low reset
//   en                  receiver enable (low aborts any frame)
//   baud_div            oversample tick period minus one
//   rx                  asynchronous serial input, idles high
//   rx_data/rx_valid    received byte and its valid flag
//   rx_ready            consumer accept
//   frame_err           one-cycle pulse: stop bit sampled low
//   overrun_err         one-cycle pulse: a completed byte was dropped
//   busy                FSM not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                 uart_clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  rx_state_e            r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic [OSW-1:0]       r_os_cnt, w_os_nxt;
  logic [BCW-1:0]       r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_sh_nxt;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_deliver;
  logic                 w_ferr;

  // Two-flop synchroniser; reset to idle level so reset never looks like a start bit.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx};
  end
  assign w_rx_s = r_sync[1];

  // Tick phase restarts from the start-bit edge because the counter sits at 0 in IDLE.
  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .clear    (r_state == IDLE),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shreg   <= w_sh_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_sh_nxt    = r_shreg;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_os_nxt    = '0;
      w_bit_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_os_nxt  = '0;
          w_bit_nxt = '0;
          if (!w_rx_s) w_state_nxt = START;
        end
        START: if (w_tick) begin
          if (r_os_cnt == OS_HALF) begin
            w_os_nxt  = '0;
            w_bit_nxt = '0;
            // Still low at mid-bit: genuine start; otherwise a glitch.
            w_state_nxt = w_rx_s ? IDLE : DATA;
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
        DATA: if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_nxt = '0;
            // LSB arrives first, so shifting right lands it in bit 0.
            w_sh_nxt = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            if (r_bit_cnt == BC_LAST) begin
              w_bit_nxt   = '0;
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_nxt = '0;
            if (w_rx_s) begin
              w_deliver   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              // Line held low (break): wait for idle so it cannot retrigger.
              w_ferr      = 1'b1;
              w_state_nxt = WAIT_IDLE;
            end
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
        WAIT_IDLE: if (w_rx_s) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output holding register. A delivery and a consume in the same cycle
  // replace the byte without dropping rx_valid.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_ferr;
      overrun_err <= 1'b0;
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shreg;
        rx_valid <= 1'b1;
      end else if (w_deliver) begin
        overrun_err <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  // Reference-side bookkeeping: a byte the consumer has not taken yet.
  bit         mdl_pending = 0;
  logic [7:0] mdl_byte = 8'h00;

  uart_rx dut (
    .uart_clk    (clk),
    .rst_n       (rst_n),
    .en          (en),
    .baud_div    (baud_div),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] d);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.data !== d)) begin
        errors++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every transfer or error pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) pop_cmp(EV_BYTE, rx_data);
      if (frame_err)            pop_cmp(EV_FERR, 8'h00);
      if (overrun_err)          pop_cmp(EV_OVR, 8'h00);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bitlen();
    return (int'(baud_div) + 1) * 16;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    cyc(bitlen());
  endtask

  // Push the expected outcome of a frame, then transmit it serially.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)          push(EV_FERR, 8'h00);
    else if (rx_ready)     push(EV_BYTE, b);
    else if (mdl_pending)  push(EV_OVR, 8'h00);
    else begin
      mdl_pending = 1;
      mdl_byte    = b;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun_err"}, overrun_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    cyc(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    cyc(5);

    // Plain byte with consumer always ready.
    send_frame(8'hA5, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid_cleared", rx_valid, 0);
    chk("a5_busy_low", busy, 0);
    cyc(10);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1);
    send_frame(8'hC3, 1);
    cyc(5);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 8'h3C);
    push(EV_BYTE, mdl_byte);
    mdl_pending = 0;
    rx_ready = 1'b1;
    cyc(2);
    chk("ovr_valid_cleared", rx_valid, 0);

    // Short glitch below half a bit.
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(60);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", rx_valid, 0);

    // Framing error followed by a break, then recovery.
    send_frame(8'h55, 0);
    repeat (10) send_bit(1'b0);
    chk("break_busy", busy, 1);
    send_bit(1'b1);
    send_frame(8'h0F, 1);
    chk("after_ferr_data", rx_data, 8'h0F);
    cyc(10);

    // Reset mid-DATA of 0x81: start, bit0=1, part of bit1=0.
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    cyc(20);
    rst_n = 1'b0;
    rx    = 1'b1;
    cyc(1);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (12) send_bit(1'b1);
    send_frame(8'h7E, 1);
    chk("post_reset_data", rx_data, 8'h7E);

    // Disable during START at baud_div=3.
    rx = 1'b0;
    cyc(10);
    en = 1'b0;
    rx = 1'b1;
    cyc(1);
    chk("en_abort_busy", busy, 0);
    cyc(4);
    en = 1'b1;
    repeat (12) send_bit(1'b1);
    chk("en_abort_valid", rx_valid, 0);

    // Same at baud_div=0, then back-to-back frames.
    baud_div = 16'd0;
    cyc(2);
    rx = 1'b0;
    cyc(4);
    en = 1'b0;
    rx = 1'b1;
    cyc(1);
    chk("en_abort0_busy", busy, 0);
    cyc(4);
    en = 1'b1;
    repeat (12) send_bit(1'b1);
    send_frame(8'hFF, 1);
    send_frame(8'h00, 1);
    chk("b2b_last_data", rx_data, 8'h00);
    cyc(10);

    // Randomised frames at random rates with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        baud_div = 16'($urandom_range(0, 3));
        cyc(2);
      end
      send_frame(8'($urandom_range(0, 255)), 1);
      cyc($urandom_range(0, 20));
    end
    cyc(20);

    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
